// File: rtl/rr_timeout_arbiter.sv
// Round-robin output-port arbiter with per-port grant timeouts loaded from header length fields.
// Emits a registered one-hot grant, its binary index and per-port timeout-expiry pulses.
module rr_timeout_arbiter #(
  parameter int NPORTS    = 5,
  parameter int LEN_W     = 12,
  parameter int FID_W     = 3,
  parameter int HEADER_ID = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NPORTS-1:0]             req,
  input  logic [NPORTS*FID_W-1:0]       flit_id,
  input  logic [NPORTS*LEN_W-1:0]       length,
  output logic [NPORTS-1:0]             grant,
  output logic                          grant_valid,
  output logic [$clog2(NPORTS)-1:0]     grant_idx,
  output logic [NPORTS-1:0]             timeout_evt
);

  localparam int IDX_W = $clog2(NPORTS);

  logic [LEN_W-1:0]  limit_q [NPORTS];
  logic [LEN_W-1:0]  limit_d [NPORTS];
  logic [LEN_W-1:0]  count_q [NPORTS];
  logic [LEN_W-1:0]  count_d [NPORTS];
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic [NPORTS-1:0] timeout_evt_q, timeout_evt_d;
  logic              grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]  cur_s, next_s, base_s;
  logic              search_en_s, found_s;
  int                span_s;

  // Next-state: header capture, retain/release decision and rotating search.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      if (flit_id[i*FID_W +: FID_W] == FID_W'(HEADER_ID)) begin
        limit_d[i] = length[i*LEN_W +: LEN_W];
      end else begin
        limit_d[i] = limit_q[i];
      end
      count_d[i] = '0;
    end
    grant_d       = '0;
    grant_idx_d   = '0;
    grant_valid_d = 1'b0;
    timeout_evt_d = '0;
    ptr_d         = ptr_q;
    cur_s         = grant_idx_q;
    next_s        = (int'(grant_idx_q) == NPORTS - 1) ? '0 : grant_idx_q + IDX_W'(1);
    base_s        = ptr_q;
    span_s        = NPORTS;
    search_en_s   = 1'b1;
    found_s       = 1'b0;

    if (grant_valid_q) begin
      // Decision uses the registered limit; a header arriving now only affects later cycles.
      if (req[cur_s] && (count_q[cur_s] < limit_q[cur_s])) begin
        grant_d        = grant_q;
        grant_idx_d    = cur_s;
        grant_valid_d  = 1'b1;
        count_d[cur_s] = count_q[cur_s] + LEN_W'(1);
        search_en_s    = 1'b0;
      end else begin
        ptr_d                = next_s;
        base_s               = next_s;
        span_s               = NPORTS - 1;
        timeout_evt_d[cur_s] = req[cur_s];
      end
    end else begin
      base_s = ptr_q;
      span_s = NPORTS;
    end

    if (search_en_s) begin
      for (int k = 0; k < NPORTS; k++) begin
        if (!found_s && (k < span_s) && req[(int'(base_s) + k) % NPORTS]) begin
          found_s                                = 1'b1;
          grant_d[(int'(base_s) + k) % NPORTS]   = 1'b1;
          grant_idx_d                            = IDX_W'((int'(base_s) + k) % NPORTS);
          grant_valid_d                          = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      found_s = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NPORTS; i++) begin
        limit_q[i] <= '0;
        count_q[i] <= '0;
      end
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      timeout_evt_q <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        limit_q[i] <= limit_d[i];
        count_q[i] <= count_d[i];
      end
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_evt_q <= timeout_evt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign timeout_evt = timeout_evt_q;

endmodule
